// File: rtl/w5300_bus_slave_log_if.sv
// Asynchronous W5300-style bus strobes and address, driven by the CPU side (master) into the chip model (slave).
interface w5300_bus_slave_log_if #(
   parameter int ADDR_W = 10
) ();
   logic [ADDR_W-1:0] addr;
   logic              cs_n;
   logic              rd_n;
   logic              wr_n;

   modport master (output addr, cs_n, rd_n, wr_n);
   modport slave  (input  addr, cs_n, rd_n, wr_n);
endinterface

// File: rtl/w5300_bus_slave_log.sv
// W5300 bus slave model: answers async cs_n/rd_n/wr_n cycles from a register file and logs every access in a FIFO.
// Optional `W5300_STROBE_CHECK_EN adds parameter MIN_STROBE and a sticky strobe_err output for short strobes.
module w5300_bus_slave_log #(
   parameter int ADDR_W    = 10,
   parameter int DATA_W    = 8,
   parameter int REG_AW    = 4,
   parameter int DEPTH_AW  = 3,
   parameter int INT_LEVEL = 1
`ifdef W5300_STROBE_CHECK_EN
   ,
   parameter int MIN_STROBE = 2
`endif
) (
   input  logic                 clk,
   input  logic                 rst_n,
   w5300_bus_slave_log_if.slave bus,
   inout  wire  [DATA_W-1:0]    d,
   output logic                 int_n,
   output logic                 log_valid,
   output logic [ADDR_W-1:0]    log_addr,
   output logic                 log_rnw,
   output logic [DATA_W-1:0]    log_data,
   input  logic                 log_rd,
   output logic                 log_ovf,
   output logic                 proto_err,
`ifdef W5300_STROBE_CHECK_EN
   output logic                 strobe_err,
`endif
   input  logic                 err_clr
);
   localparam int DEPTH = 2**DEPTH_AW;
   localparam int NREG  = 2**REG_AW;
   localparam int CW    = DEPTH_AW + 1;

   typedef enum logic [1:0] {IDLE, RD, WR, ERR} state_t;
   state_t state_q, state_d;

   logic [1:0]        cs_sync, rd_sync, wr_sync;
   logic              rd_s, wr_s;
   logic [DATA_W-1:0] regfile [NREG];
   logic [ADDR_W-1:0] cap_addr;
   logic [DATA_W-1:0] cap_data;
   logic [REG_AW-1:0] cap_idx;
   logic              push, push_rnw, reg_we, proto_set;
   logic [DATA_W-1:0] push_data;

   logic [ADDR_W-1:0]   f_addr [DEPTH];
   logic                f_rnw  [DEPTH];
   logic [DATA_W-1:0]   f_data [DEPTH];
   logic [DEPTH_AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0]       count_q, count_d;
   logic                full, pop, push_ok, ovf_set;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cs_sync <= '1;
         rd_sync <= '1;
         wr_sync <= '1;
      end else begin
         cs_sync <= {cs_sync[0], bus.cs_n};
         rd_sync <= {rd_sync[0], bus.rd_n};
         wr_sync <= {wr_sync[0], bus.wr_n};
      end
   end

   assign rd_s = ~cs_sync[1] & ~rd_sync[1];
   assign wr_s = ~cs_sync[1] & ~wr_sync[1];

   // Read data follows the raw strobes so the bus sees it without synchronizer delay.
   assign d = (~bus.cs_n & ~bus.rd_n) ? regfile[bus.addr[REG_AW-1:0]] : 'z;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_addr <= '0;
         cap_data <= '0;
      end else if (rd_s | wr_s) begin
         cap_addr <= bus.addr;
         cap_data <= d;
      end
   end

   assign cap_idx = cap_addr[REG_AW-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      push     = 1'b0;
      push_rnw = 1'b0;
      reg_we   = 1'b0;
      case (state_q)
         IDLE: begin
            if (rd_s & wr_s) state_d = ERR;
            else if (rd_s)   state_d = RD;
            else if (wr_s)   state_d = WR;
         end
         RD: begin
            if (wr_s) state_d = ERR;
            else if (!rd_s) begin
               state_d  = IDLE;
               push     = 1'b1;
               push_rnw = 1'b1;
            end
         end
         WR: begin
            if (rd_s) state_d = ERR;
            else if (!wr_s) begin
               state_d = IDLE;
               push    = 1'b1;
               reg_we  = 1'b1;
            end
         end
         ERR: begin
            if (!rd_s && !wr_s) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign proto_set = (state_d == ERR);
   assign push_data = push_rnw ? regfile[cap_idx] : cap_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      regfile <= '{default: '0};
      else if (reg_we) regfile[cap_idx] <= cap_data;
   end

   // A pop in the same cycle frees the slot, so a push into a full FIFO is only dropped without one.
   assign full     = (count_q == CW'(DEPTH));
   assign pop      = log_rd & log_valid;
   assign push_ok  = push & (~full | pop);
   assign ovf_set  = push & full & ~pop;
   assign count_d  = count_q + CW'(push_ok) - CW'(pop);

   always_ff @(posedge clk) begin
      if (push_ok) begin
         f_addr[wr_ptr] <= cap_addr;
         f_rnw[wr_ptr]  <= push_rnw;
         f_data[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count_q   <= '0;
         int_n     <= 1'b1;
         log_ovf   <= 1'b0;
         proto_err <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         count_q <= count_d;
         int_n   <= ~(count_d >= CW'(INT_LEVEL));
         if (ovf_set)      log_ovf <= 1'b1;
         else if (err_clr) log_ovf <= 1'b0;
         if (proto_set)    proto_err <= 1'b1;
         else if (err_clr) proto_err <= 1'b0;
      end
   end

   assign log_valid = (count_q != '0);
   assign log_addr  = f_addr[rd_ptr];
   assign log_rnw   = f_rnw[rd_ptr];
   assign log_data  = f_data[rd_ptr];

`ifdef W5300_STROBE_CHECK_EN
   logic [7:0] strobe_cnt;
   logic       strobe_short;

   // Counts cycles the FSM will spend in RD/WR, so a one-cycle strobe reads 1 at release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) strobe_cnt <= '0;
      else if (state_d == RD || state_d == WR) begin
         if (strobe_cnt != 8'hFF) strobe_cnt <= strobe_cnt + 8'd1;
      end else strobe_cnt <= '0;
   end

   assign strobe_short = push & (strobe_cnt < 8'(MIN_STROBE));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)            strobe_err <= 1'b0;
      else if (strobe_short) strobe_err <= 1'b1;
      else if (err_clr)      strobe_err <= 1'b0;
   end
`endif
endmodule

// File: tb/tb_w5300_bus_slave_log.sv
// Self-checking bench for w5300_bus_slave_log: randomized bus cycles against a queue/array reference model.
// Build with +define+W5300_STROBE_CHECK_EN to also exercise strobe_err.
module tb_w5300_bus_slave_log;
   localparam int ADDR_W    = 10;
   localparam int DATA_W    = 8;
   localparam int DEPTH     = 8;
   localparam int INT_LEVEL = 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   w5300_bus_slave_log_if #(.ADDR_W(ADDR_W)) bus ();
   wire  [DATA_W-1:0] d;
   logic              tb_oe;
   logic [DATA_W-1:0] tb_d;
   assign d = tb_oe ? tb_d : 'z;

   logic              int_n, log_valid, log_rnw, log_ovf, proto_err, log_rd, err_clr;
   logic [ADDR_W-1:0] log_addr;
   logic [DATA_W-1:0] log_data;
`ifdef W5300_STROBE_CHECK_EN
   logic              strobe_err;
`endif

   w5300_bus_slave_log #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .REG_AW(4), .DEPTH_AW(3), .INT_LEVEL(INT_LEVEL)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .d(d),
      .int_n(int_n), .log_valid(log_valid), .log_addr(log_addr), .log_rnw(log_rnw),
      .log_data(log_data), .log_rd(log_rd), .log_ovf(log_ovf), .proto_err(proto_err),
`ifdef W5300_STROBE_CHECK_EN
      .strobe_err(strobe_err),
`endif
      .err_clr(err_clr)
   );

   typedef struct packed {
      logic [ADDR_W-1:0] a;
      logic              rnw;
      logic [DATA_W-1:0] dat;
   } ent_t;

   ent_t        mq[$];
   logic [7:0]  mreg [16];
   logic        movf;
   int          checks = 0;
   int          errors = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      mq.delete();
      for (int i = 0; i < 16; i++) mreg[i] = '0;
      movf = 1'b0;
   endtask

   task automatic model_push(input ent_t e);
      if (mq.size() < DEPTH) mq.push_back(e);
      else movf = 1'b1;
   endtask

   task automatic do_pop();
      log_rd = 1'b1;
      tick();
      log_rd = 1'b0;
   endtask

   task automatic do_clr();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      movf = 1'b0;
   endtask

   // Write cycle; holds addr/d through the synchronizer delay and returns once the entry is visible.
   task automatic bus_write(input logic [ADDR_W-1:0] a, input logic [7:0] v, input int len, input bit pop_at_push);
      bus.addr = a; tb_d = v; tb_oe = 1'b1;
      bus.cs_n = 1'b0; bus.wr_n = 1'b0;
      repeat (len) tick();
      bus.wr_n = 1'b1; bus.cs_n = 1'b1;
      tick(); tick();
      if (pop_at_push) log_rd = 1'b1;
      tick();
      log_rd = 1'b0; tb_oe = 1'b0;
      if (pop_at_push && mq.size() > 0) void'(mq.pop_front());
      model_push({a, 1'b0, v});
      mreg[a[3:0]] = v;
   endtask

   task automatic bus_read(input logic [ADDR_W-1:0] a, input int len, output logic [7:0] seen);
      bus.addr = a; tb_oe = 1'b0;
      bus.cs_n = 1'b0; bus.rd_n = 1'b0;
      #1 seen = d;
      repeat (len) tick();
      bus.rd_n = 1'b1; bus.cs_n = 1'b1;
      repeat (3) tick();
      model_push({a, 1'b1, mreg[a[3:0]]});
   endtask

   task automatic test_reset();
      logic [7:0] seen;
      rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      model_reset();
      checks++; if (int_n !== 1'b1)     begin errors++; $display("FAIL reset_int_n got %b exp 1", int_n); end
      checks++; if (log_valid !== 1'b0) begin errors++; $display("FAIL reset_log_valid got %b exp 0", log_valid); end
      checks++; if (log_ovf !== 1'b0)   begin errors++; $display("FAIL reset_log_ovf got %b exp 0", log_ovf); end
      checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL reset_proto_err got %b exp 0", proto_err); end
      bus_read(10'h3F3, 2, seen);
      checks++; if (seen !== mreg[3]) begin errors++; $display("FAIL reset_regfile got %h exp %h", seen, mreg[3]); end
      while (mq.size() > 0) begin
         checks++;
         if (log_valid !== 1'b1 || log_addr !== mq[0].a || log_rnw !== mq[0].rnw || log_data !== mq[0].dat) begin
            errors++;
            $display("FAIL reset_head got v=%b a=%h r=%b d=%h exp a=%h r=%b d=%h",
                     log_valid, log_addr, log_rnw, log_data, mq[0].a, mq[0].rnw, mq[0].dat);
         end
         do_pop(); void'(mq.pop_front());
      end
   endtask

   task automatic test_write_latency();
      bus.addr = 10'h005; tb_d = 8'hA5; tb_oe = 1'b1;
      bus.cs_n = 1'b0; bus.wr_n = 1'b0;
      repeat (4) tick();
      bus.wr_n = 1'b1; bus.cs_n = 1'b1;
      tick(); tick();
      checks++; if (log_valid !== 1'b0) begin errors++; $display("FAIL lat_early got %b exp 0", log_valid); end
      tick();
      tb_oe = 1'b0;
      checks++; if (log_valid !== 1'b1) begin errors++; $display("FAIL lat_valid got %b exp 1", log_valid); end
      checks++;
      if (log_addr !== 10'h005 || log_rnw !== 1'b0 || log_data !== 8'hA5) begin
         errors++; $display("FAIL lat_entry got a=%h r=%b d=%h exp a=005 r=0 d=a5", log_addr, log_rnw, log_data);
      end
      checks++; if (int_n !== 1'b0) begin errors++; $display("FAIL lat_int_n got %b exp 0", int_n); end
      mreg[5] = 8'hA5;
      do_pop();
      checks++; if (log_valid !== 1'b0) begin errors++; $display("FAIL lat_pop_valid got %b exp 0", log_valid); end
      checks++; if (int_n !== 1'b1) begin errors++; $display("FAIL lat_pop_int_n got %b exp 1", int_n); end
   endtask

   task automatic test_alias();
      logic [7:0] seen;
      bus_write(10'h012, 8'h3C, 3, 1'b0);
      bus_read(10'h002, 3, seen);
      checks++; if (seen !== mreg[2]) begin errors++; $display("FAIL alias_d got %h exp %h", seen, mreg[2]); end
      while (mq.size() > 0) begin
         checks++;
         if (log_valid !== 1'b1 || log_addr !== mq[0].a || log_rnw !== mq[0].rnw || log_data !== mq[0].dat) begin
            errors++;
            $display("FAIL alias_head got v=%b a=%h r=%b d=%h exp a=%h r=%b d=%h",
                     log_valid, log_addr, log_rnw, log_data, mq[0].a, mq[0].rnw, mq[0].dat);
         end
         do_pop(); void'(mq.pop_front());
      end
   endtask

   task automatic test_random();
      logic [ADDR_W-1:0] a;
      logic [7:0]        v, seen, exp;
      int                op, len;
      for (int n = 0; n < 30; n++) begin
         op  = int'($urandom_range(0, 2));
         a   = ADDR_W'($urandom);
         v   = 8'($urandom);
         len = int'($urandom_range(2, 4));
         if (op == 0) bus_write(a, v, len, 1'b0);
         else if (op == 1) begin
            exp = mreg[a[3:0]];
            bus_read(a, len, seen);
            checks++; if (seen !== exp) begin errors++; $display("FAIL rand_read_d a=%h got %h exp %h", a, seen, exp); end
         end else if (mq.size() > 0) begin
            checks++;
            if (log_valid !== 1'b1 || log_addr !== mq[0].a || log_rnw !== mq[0].rnw || log_data !== mq[0].dat) begin
               errors++;
               $display("FAIL rand_head got v=%b a=%h r=%b d=%h exp a=%h r=%b d=%h",
                        log_valid, log_addr, log_rnw, log_data, mq[0].a, mq[0].rnw, mq[0].dat);
            end
            do_pop(); void'(mq.pop_front());
         end else begin
            do_pop();
            checks++; if (log_valid !== 1'b0) begin errors++; $display("FAIL rand_empty_pop got %b exp 0", log_valid); end
         end
      end
      checks++; if (log_ovf !== movf) begin errors++; $display("FAIL rand_ovf got %b exp %b", log_ovf, movf); end
      checks++;
      if (int_n !== ((mq.size() >= INT_LEVEL) ? 1'b0 : 1'b1)) begin
         errors++; $display("FAIL rand_int_n got %b exp count %0d", int_n, mq.size());
      end
      while (mq.size() > 0) begin
         checks++;
         if (log_valid !== 1'b1 || log_addr !== mq[0].a || log_rnw !== mq[0].rnw || log_data !== mq[0].dat) begin
            errors++;
            $display("FAIL rand_drain got v=%b a=%h r=%b d=%h exp a=%h r=%b d=%h",
                     log_valid, log_addr, log_rnw, log_data, mq[0].a, mq[0].rnw, mq[0].dat);
         end
         do_pop(); void'(mq.pop_front());
      end
      do_clr();
   endtask

   task automatic test_overflow();
      for (int i = 1; i <= 9; i++) bus_write(ADDR_W'(i), 8'(i), 2, 1'b0);
      checks++; if (log_ovf !== movf || movf !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", log_ovf); end
      checks++; if (int_n !== 1'b0) begin errors++; $display("FAIL ovf_int_n got %b exp 0", int_n); end
      while (mq.size() > 0) begin
         checks++;
         if (log_valid !== 1'b1 || log_data !== mq[0].dat || log_addr !== mq[0].a) begin
            errors++; $display("FAIL ovf_order got v=%b a=%h d=%h exp a=%h d=%h",
                               log_valid, log_addr, log_data, mq[0].a, mq[0].dat);
         end
         do_pop(); void'(mq.pop_front());
      end
      checks++; if (log_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty got %b exp 0", log_valid); end
      do_clr();
      checks++; if (log_ovf !== 1'b0) begin errors++; $display("FAIL ovf_clr got %b exp 0", log_ovf); end
   endtask

   task automatic test_full_pop();
      for (int i = 0; i < DEPTH; i++) bus_write(ADDR_W'(10'h100 + i), 8'(8'h40 + i), 2, 1'b0);
      bus_write(10'h1AB, 8'h77, 2, 1'b1);
      checks++; if (log_ovf !== 1'b0) begin errors++; $display("FAIL fullpop_ovf got %b exp 0", log_ovf); end
      for (int i = 0; i < DEPTH; i++) begin
         checks++;
         if (log_valid !== 1'b1 || log_addr !== mq[0].a || log_data !== mq[0].dat) begin
            errors++; $display("FAIL fullpop_head got v=%b a=%h d=%h exp a=%h d=%h",
                               log_valid, log_addr, log_data, mq[0].a, mq[0].dat);
         end
         do_pop(); void'(mq.pop_front());
      end
      checks++; if (log_valid !== 1'b0) begin errors++; $display("FAIL fullpop_count got %b exp 0", log_valid); end
   endtask

   task automatic test_proto();
      logic [7:0] seen, exp;
      bus.addr = 10'h0C7; tb_oe = 1'b0;
      bus.cs_n = 1'b0; bus.rd_n = 1'b0; bus.wr_n = 1'b0;
      repeat (3) tick();
      bus.cs_n = 1'b1; bus.rd_n = 1'b1; bus.wr_n = 1'b1;
      repeat (4) tick();
      checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_set got %b exp 1", proto_err); end
      checks++; if (log_valid !== 1'b0) begin errors++; $display("FAIL proto_nolog got %b exp 0", log_valid); end
      exp = mreg[7];
      bus_read(10'h007, 2, seen);
      checks++; if (seen !== exp) begin errors++; $display("FAIL proto_regfile got %h exp %h", seen, exp); end
      do_pop(); void'(mq.pop_front());
      do_clr();
      checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL proto_clr got %b exp 0", proto_err); end
      bus_write(10'h0C7, 8'h5A, 3, 1'b0);
      checks++;
      if (log_valid !== 1'b1 || log_addr !== mq[0].a || log_rnw !== mq[0].rnw || log_data !== mq[0].dat) begin
         errors++; $display("FAIL proto_after got v=%b a=%h r=%b d=%h exp a=%h r=%b d=%h",
                            log_valid, log_addr, log_rnw, log_data, mq[0].a, mq[0].rnw, mq[0].dat);
      end
      do_pop(); void'(mq.pop_front());
   endtask

   task automatic test_reset_mid();
      logic [7:0] seen;
      bus_write(10'h011, 8'h99, 2, 1'b0);
      bus.addr = 10'h022; tb_d = 8'h66; tb_oe = 1'b1;
      bus.cs_n = 1'b0; bus.wr_n = 1'b0;
      tick(); tick();
      rst_n = 1'b0;
      #1;
      checks++; if (int_n !== 1'b1 || log_valid !== 1'b0 || log_ovf !== 1'b0 || proto_err !== 1'b0) begin
         errors++; $display("FAIL rstmid_outputs got int_n=%b v=%b ovf=%b perr=%b exp 1 0 0 0",
                            int_n, log_valid, log_ovf, proto_err);
      end
      bus.cs_n = 1'b1; bus.wr_n = 1'b1; tb_oe = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      model_reset();
      repeat (4) tick();
      checks++; if (log_valid !== 1'b0) begin errors++; $display("FAIL rstmid_nolog got %b exp 0", log_valid); end
      bus_read(10'h011, 2, seen);
      checks++; if (seen !== mreg[1]) begin errors++; $display("FAIL rstmid_reg1 got %h exp %h", seen, mreg[1]); end
      bus_read(10'h022, 2, seen);
      checks++; if (seen !== mreg[2]) begin errors++; $display("FAIL rstmid_reg2 got %h exp %h", seen, mreg[2]); end
      while (mq.size() > 0) begin
         checks++;
         if (log_valid !== 1'b1 || log_addr !== mq[0].a || log_rnw !== mq[0].rnw || log_data !== mq[0].dat) begin
            errors++; $display("FAIL rstmid_head got v=%b a=%h r=%b d=%h exp a=%h r=%b d=%h",
                               log_valid, log_addr, log_rnw, log_data, mq[0].a, mq[0].rnw, mq[0].dat);
         end
         do_pop(); void'(mq.pop_front());
      end
   endtask

`ifdef W5300_STROBE_CHECK_EN
   task automatic test_strobe();
      bus_write(10'h034, 8'h22, 2, 1'b0);
      checks++; if (strobe_err !== 1'b0) begin errors++; $display("FAIL strobe_ok got %b exp 0", strobe_err); end
      do_pop(); void'(mq.pop_front());
      bus_write(10'h033, 8'h11, 1, 1'b0);
      checks++; if (strobe_err !== 1'b1) begin errors++; $display("FAIL strobe_short got %b exp 1", strobe_err); end
      checks++;
      if (log_valid !== 1'b1 || log_addr !== mq[0].a || log_data !== mq[0].dat) begin
         errors++; $display("FAIL strobe_logged got v=%b a=%h d=%h exp a=%h d=%h",
                            log_valid, log_addr, log_data, mq[0].a, mq[0].dat);
      end
      do_pop(); void'(mq.pop_front());
      do_clr();
      checks++; if (strobe_err !== 1'b0) begin errors++; $display("FAIL strobe_clr got %b exp 0", strobe_err); end
   endtask
`endif

   initial begin
      bus.addr = '0; bus.cs_n = 1'b1; bus.rd_n = 1'b1; bus.wr_n = 1'b1;
      tb_oe = 1'b0; tb_d = '0; log_rd = 1'b0; err_clr = 1'b0;
      model_reset();
      test_reset();
      test_write_latency();
      test_alias();
      test_random();
      test_overflow();
      test_full_pop();
      test_proto();
      test_reset_mid();
`ifdef W5300_STROBE_CHECK_EN
      test_strobe();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
